// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side signals of the decode queue.
// The slave modport is the queue's view; the master modport is the fetch/execute view.
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int EN_M  = 0
);
    localparam int AW = 14 + 8 * EN_M;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on a rising clk edge when valid and ready are
    // both high and i_flush is low; valid never waits on ready, and ready never waits on valid.
    logic [31:0]      i_inst;
    logic [XLEN-1:0]  i_pc;
    logic             i_valid;
    logic             o_ready;
    logic             o_valid;
    logic             i_ready;
    logic             i_flush;
    logic [XLEN-1:0]  o_pc;
    logic [4:0]       o_rs1_addr;
    logic [4:0]       o_rs2_addr;
    logic [4:0]       o_rd_addr;
    logic [2:0]       o_func3;
    logic [XLEN-1:0]  o_imm;
    logic [AW-1:0]    o_alu;
    logic [10:0]      o_opcode;
    logic             o_illegal;
    logic [CW-1:0]    o_count;

    modport slave (
        input  i_inst, i_pc, i_valid, i_ready, i_flush,
        output o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_func3, o_imm, o_alu, o_opcode, o_illegal, o_count
    );

    modport master (
        output i_inst, i_pc, i_valid, i_ready, i_flush,
        input  o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_func3, o_imm, o_alu, o_opcode, o_illegal, o_count
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage: decodes each accepted instruction combinationally and
// buffers the decoded entries in a DEPTH-entry FIFO toward execute.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int EN_M  = 0
) (
    input  logic          clk,
    input  logic          reset,
    decode_queue_if.slave dq
);
    localparam int AW = 14 + 8 * EN_M;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLL = 2, ALU_SRL = 3, ALU_SRA = 4;
    localparam int ALU_SLT = 5, ALU_SLTU = 6, ALU_XOR = 7, ALU_OR = 8, ALU_AND = 9;
    localparam int ALU_BEQ = 10, ALU_BNE = 11, ALU_BGE = 12, ALU_BGEU = 13;

    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_B = 7'h63, OP_L = 7'h03;
    localparam logic [6:0] OP_S = 7'h23, OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_LUI = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17, OP_SYS = 7'h73, OP_FENCE = 7'h0f;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   alu;
        logic [10:0]     opcode;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [31:0] inst;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    assign inst   = dq.i_inst;
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic [31:0] i_imm32, s_imm32, b_imm32, j_imm32, u_imm32, f_imm32;
    assign i_imm32 = {{20{inst[31]}}, inst[31:20]};
    assign s_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign u_imm32 = {inst[31:12], 12'h000};
    assign f_imm32 = {20'h00000, inst[31:20]};

    logic [AW-1:0]   alu_base;
    logic [AW-1:0]   alu;
    logic [10:0]     opc;
    logic [XLEN-1:0] imm;
    logic            illegal;
    entry_t          dec;

    // Shared funct3 mapping for register and immediate arithmetic.
    always_comb begin
        alu_base = '0;
        case (funct3)
            3'b000: alu_base[ALU_ADD]  = 1'b1;
            3'b001: alu_base[ALU_SLL]  = 1'b1;
            3'b010: alu_base[ALU_SLT]  = 1'b1;
            3'b011: alu_base[ALU_SLTU] = 1'b1;
            3'b100: alu_base[ALU_XOR]  = 1'b1;
            3'b101: alu_base[ALU_SRL]  = 1'b1;
            3'b110: alu_base[ALU_OR]   = 1'b1;
            3'b111: alu_base[ALU_AND]  = 1'b1;
        endcase
    end

    always_comb begin
        alu     = '0;
        opc     = '0;
        imm     = '0;
        illegal = 1'b0;
        case (inst[6:0])
            OP_R: begin
                opc[0] = 1'b1;
                case (funct7)
                    7'h00: alu = alu_base;
                    7'h20: begin
                        if (funct3 == 3'b000)      alu[ALU_SUB] = 1'b1;
                        else if (funct3 == 3'b101) alu[ALU_SRA] = 1'b1;
                        else                       illegal = 1'b1;
                    end
                    7'h01: begin
                        if (EN_M != 0) alu = AW'({8'b1 << funct3, 14'b0});
                        else           illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                opc[1] = 1'b1;
                imm    = sx(i_imm32);
                alu    = alu_base;
                if (funct3 == 3'b001 && funct7 != 7'h00) illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20) begin
                        alu          = '0;
                        alu[ALU_SRA] = 1'b1;
                    end else if (funct7 != 7'h00) begin
                        illegal = 1'b1;
                    end
                end
            end
            OP_B: begin
                opc[2] = 1'b1;
                imm    = sx(b_imm32);
                case (funct3)
                    3'b000:  alu[ALU_BEQ]  = 1'b1;
                    3'b001:  alu[ALU_BNE]  = 1'b1;
                    3'b100:  alu[ALU_SLT]  = 1'b1;
                    3'b101:  alu[ALU_BGE]  = 1'b1;
                    3'b110:  alu[ALU_SLTU] = 1'b1;
                    3'b111:  alu[ALU_BGEU] = 1'b1;
                    default: alu = '0;
                endcase
            end
            OP_L:     begin opc[3]  = 1'b1; imm = sx(i_imm32); alu[ALU_ADD] = 1'b1; end
            OP_S:     begin opc[4]  = 1'b1; imm = sx(s_imm32); alu[ALU_ADD] = 1'b1; end
            OP_JAL:   begin opc[5]  = 1'b1; imm = sx(j_imm32); alu[ALU_ADD] = 1'b1; end
            OP_JALR:  begin opc[6]  = 1'b1; imm = sx(i_imm32); alu[ALU_ADD] = 1'b1; end
            OP_LUI:   begin opc[7]  = 1'b1; imm = sx(u_imm32); alu[ALU_ADD] = 1'b1; end
            OP_AUIPC: begin opc[8]  = 1'b1; imm = sx(u_imm32); alu[ALU_ADD] = 1'b1; end
            OP_SYS:   begin opc[9]  = 1'b1; alu[ALU_ADD] = 1'b1; end
            OP_FENCE: begin opc[10] = 1'b1; imm = XLEN'(f_imm32); alu[ALU_ADD] = 1'b1; end
            default:  illegal = 1'b1;
        endcase
        // Illegal entries still flow down the pipe, but carry no operation.
        if (illegal) begin
            alu = '0;
            opc = '0;
            imm = '0;
        end
    end

    always_comb begin
        dec         = '0;
        dec.pc      = dq.i_pc;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.func3   = funct3;
        dec.imm     = imm;
        dec.alu     = alu;
        dec.opcode  = opc;
        dec.illegal = illegal;
    end

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ready, valid, push, pop;
    entry_t        head;

    assign ready = count < CW'(DEPTH);
    assign valid = count != '0;
    assign push  = dq.i_valid && ready && !dq.i_flush;
    assign pop   = valid && dq.i_ready && !dq.i_flush;

    always_ff @(posedge clk) begin
        if (reset || dq.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head = valid ? mem[rd_ptr] : '0;

    assign dq.o_ready    = ready;
    assign dq.o_valid    = valid;
    assign dq.o_count    = count;
    assign dq.o_pc       = head.pc;
    assign dq.o_rs1_addr = head.rs1;
    assign dq.o_rs2_addr = head.rs2;
    assign dq.o_rd_addr  = head.rd;
    assign dq.o_func3    = head.func3;
    assign dq.o_imm      = head.imm;
    assign dq.o_alu      = head.alu;
    assign dq.o_opcode   = head.opcode;
    assign dq.o_illegal  = head.illegal;
endmodule
